// File: rtl/egress_meta_arbiter_if.sv
// egress_meta_arbiter_if: egress capture, software read/ack and status signals of the metadata arbiter.
`timescale 1ns/1ps
`default_nettype none

interface egress_meta_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int PAYLOAD_W = 28
);
  logic [NUM_PORTS-1:0]           eg_strobe;
  logic [NUM_PORTS*PAYLOAD_W-1:0] eg_data;
  logic                           flush;
  logic                           meta_ack;
  logic [31:0]                    meta_out;
  logic [NUM_PORTS-1:0]           pending;
  logic [NUM_PORTS-1:0]           overflow;
  logic                           busy;

  modport master (
    output eg_strobe, eg_data, flush, meta_ack,
    input  meta_out, pending, overflow, busy
  );

  modport slave (
    input  eg_strobe, eg_data, flush, meta_ack,
    output meta_out, pending, overflow, busy
  );
endinterface

`default_nettype wire

// File: rtl/egress_meta_arbiter.sv
// egress_meta_arbiter: per-port metadata holding slots shared round-robin onto one
// software-acknowledged 32-bit read word {valid, ovf, port[1:0], payload[27:0]}.
`timescale 1ns/1ps
`default_nettype none

module egress_meta_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PAYLOAD_W = 28
) (
  input wire logic             clk,
  input wire logic             reset_n,
  egress_meta_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    PRESENT = 2'd2,
    RETIRE  = 2'd3
  } state_e;

  state_e                 state_q;
  logic [1:0]             rr_ptr_q;
  logic [1:0]             grant_q;
  logic [PAYLOAD_W-1:0]   slot_q [NUM_PORTS];
  logic [NUM_PORTS-1:0]   pending_q;
  logic [NUM_PORTS-1:0]   pending_d;
  logic [NUM_PORTS-1:0]   overflow_q;
  logic [NUM_PORTS-1:0]   overflow_d;
  logic [NUM_PORTS-1:0]   slot_we;
  logic [NUM_PORTS-1:0]   retire_hit;
  logic                   ack_q;
  logic                   ack_rise;
  logic [31:0]            meta_out_q;
  logic                   sel_found;
  logic [1:0]             sel_port;
  logic [1:0]             search_idx;

  assign ack_rise = bus.meta_ack && !ack_q;

  // Lowest offset from rr_ptr wins, so scan offsets downwards and let the last hit stick.
  always_comb begin : rr_search
    sel_found  = 1'b0;
    sel_port   = rr_ptr_q;
    search_idx = rr_ptr_q;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      search_idx = 2'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (pending_q[search_idx]) begin
        sel_found = 1'b1;
        sel_port  = search_idx;
      end
    end
  end

  // A strobe into the slot being retired this cycle refills it instead of overflowing.
  always_comb begin : capture
    pending_d  = pending_q;
    overflow_d = overflow_q;
    slot_we    = '0;
    retire_hit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      retire_hit[i] = (state_q == RETIRE) && (grant_q == 2'(i));
      if (bus.eg_strobe[i]) begin
        if (!pending_q[i] || retire_hit[i]) begin
          slot_we[i]   = 1'b1;
          pending_d[i] = 1'b1;
        end else begin
          overflow_d[i] = 1'b1;
        end
      end else if (retire_hit[i]) begin
        pending_d[i] = 1'b0;
      end
      if (retire_hit[i]) begin
        overflow_d[i] = 1'b0;
      end
    end
    if (bus.flush) begin
      pending_d  = '0;
      overflow_d = '0;
      slot_we    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      ack_q      <= 1'b0;
      meta_out_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      ack_q      <= bus.meta_ack;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (slot_we[i]) begin
          slot_q[i] <= bus.eg_data[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
      if (bus.flush) begin
        state_q    <= IDLE;
        meta_out_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (|pending_q) begin
              state_q <= SELECT;
            end
          end
          SELECT: begin
            if (sel_found) begin
              grant_q    <= sel_port;
              meta_out_q <= {1'b1, overflow_d[sel_port], sel_port, slot_q[sel_port]};
              state_q    <= PRESENT;
            end else begin
              state_q <= IDLE;
            end
          end
          PRESENT: begin
            if (ack_rise) begin
              meta_out_q <= '0;
              state_q    <= RETIRE;
            end
          end
          RETIRE: begin
            rr_ptr_q <= (grant_q == 2'(NUM_PORTS - 1)) ? 2'd0 : grant_q + 2'd1;
            state_q  <= (|pending_d) ? SELECT : IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.meta_out = meta_out_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_egress_meta_arbiter.sv
// tb_egress_meta_arbiter: directed and randomized scoreboard bench; expected words come
// from a transaction-level slot/round-robin model and are checked by a negedge monitor.
`timescale 1ns/1ps
`default_nettype none

module tb_egress_meta_arbiter;
  localparam int NP = 4;
  localparam int PW = 28;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  egress_meta_arbiter_if #(.NUM_PORTS(NP), .PAYLOAD_W(PW)) bus ();

  egress_meta_arbiter #(.NUM_PORTS(NP), .PAYLOAD_W(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  // Reference model: one slot per port, a pending/overflow flag each, and the round-robin start.
  bit          m_pend[NP];
  logic [PW-1:0] m_slot[NP];
  bit          m_ovf[NP];
  int          m_rr;
  int          cur;

  bit          prev_valid = 1'b0;
  logic [31:0] prev_word  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int next_grant();
    for (int k = 0; k < NP; k++) begin
      if (m_pend[(m_rr + k) % NP]) return (m_rr + k) % NP;
    end
    return -1;
  endfunction

  function automatic logic [31:0] word_of(input int p);
    return {1'b1, m_ovf[p], 2'(p), m_slot[p]};
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NP; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [31:0] ovf_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NP; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  function automatic logic [NP*PW-1:0] rand_data();
    logic [NP*PW-1:0] d;
    for (int i = 0; i < NP; i++) d[i*PW +: PW] = PW'($urandom);
    return d;
  endfunction

  task automatic model_strobe(input int p, input logic [PW-1:0] d);
    if (!m_pend[p]) begin
      m_pend[p] = 1'b1;
      m_slot[p] = d;
    end else begin
      m_ovf[p] = 1'b1;
    end
  endtask

  task automatic model_retire(input int p);
    m_pend[p] = 1'b0;
    m_ovf[p]  = 1'b0;
    m_rr      = (p + 1) % NP;
  endtask

  task automatic model_clear(input bit keep_rr);
    for (int i = 0; i < NP; i++) begin
      m_pend[i] = 1'b0;
      m_ovf[i]  = 1'b0;
      m_slot[i] = '0;
    end
    if (!keep_rr) m_rr = 0;
    exp_q.delete();
    cur = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_strobe(input logic [NP-1:0] mask, input logic [NP*PW-1:0] data);
    bus.eg_strobe = mask;
    bus.eg_data   = data;
    for (int i = 0; i < NP; i++) begin
      if (mask[i]) model_strobe(i, data[i*PW +: PW]);
    end
    tick();
    bus.eg_strobe = '0;
  endtask

  task automatic issue_first();
    cur = next_grant();
    if (cur >= 0) exp_q.push_back(word_of(cur));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.meta_out[31] && n < 30) begin
      tick();
      n++;
    end
    if (!bus.meta_out[31]) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no valid word within 30 cycles (meta_out %h)", name, bus.meta_out);
    end
  endtask

  // Ack stays high for 'hold' cycles (>=2); the retire cycle optionally carries a strobe.
  task automatic ack_pulse(input int hold, input int rs_port, input logic [PW-1:0] rs_data);
    wait_valid("ack_wait");
    bus.meta_ack = 1'b1;
    tick();
    if (rs_port >= 0) begin
      bus.eg_strobe[rs_port]          = 1'b1;
      bus.eg_data[rs_port*PW +: PW]   = rs_data;
    end
    model_retire(cur);
    if (rs_port >= 0) model_strobe(rs_port, rs_data);
    cur = next_grant();
    if (cur >= 0) exp_q.push_back(word_of(cur));
    tick();
    bus.eg_strobe = '0;
    for (int i = 2; i < hold; i++) tick();
    bus.meta_ack = 1'b0;
    tick();
  endtask

  task automatic drain();
    while (cur >= 0) ack_pulse(2, -1, '0);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.meta_out[31] && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL word_unexpected: got %h, no word expected", bus.meta_out);
        end else begin
          check("word", bus.meta_out, exp_q.pop_front());
        end
      end else if (bus.meta_out[31]) begin
        check("word_stable", bus.meta_out, prev_word);
      end else begin
        check("idle_zero", bus.meta_out, 32'h0);
      end
      prev_valid = bus.meta_out[31];
      prev_word  = bus.meta_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NP*PW-1:0] d;
    bus.eg_strobe = '0;
    bus.eg_data   = '0;
    bus.flush     = 1'b0;
    bus.meta_ack  = 1'b0;
    model_clear(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_meta_out", bus.meta_out, 32'h0);
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_overflow", 32'(bus.overflow), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset_n = 1'b1;
    tick();

    // Single word on port 2: valid exactly two cycles after pending appears.
    d = '0;
    d[2*PW +: PW] = 28'h0ABCDEF;
    drive_strobe(4'b0100, d);
    issue_first();
    check("t1_pending", 32'(bus.pending), 32'h4);
    tick();
    check("t1_not_yet", 32'(bus.meta_out[31]), 32'h0);
    tick();
    check("t1_latency", bus.meta_out, 32'hA0ABCDEF);
    ack_pulse(2, -1, '0);
    check("t1_cleared_out", bus.meta_out, 32'h0);
    check("t1_cleared_pend", 32'(bus.pending), 32'h0);

    // Round-robin order starting at the pointer left by the previous grant.
    drive_strobe(4'b1011, rand_data());
    issue_first();
    drain();
    drive_strobe(4'b1001, rand_data());
    issue_first();
    drain();

    // Overflow: second strobe on a full slot is dropped and flagged.
    drive_strobe(4'b0010, rand_data());
    drive_strobe(4'b0010, rand_data());
    check("t3_overflow", 32'(bus.overflow), 32'h2);
    issue_first();
    drain();
    check("t3_ovf_cleared", 32'(bus.overflow), 32'h0);
    check("t3_pend_cleared", 32'(bus.pending), 32'h0);

    // Held ack retires only one word.
    drive_strobe(4'b0101, rand_data());
    issue_first();
    ack_pulse(6, -1, '0);
    check("t4_still_valid", 32'(bus.meta_out[31]), 32'h1);
    check("t4_pending", 32'(bus.pending), pend_vec());
    drain();

    // Refill of port 0 in its own retire cycle.
    drive_strobe(4'b0001, rand_data());
    issue_first();
    ack_pulse(2, 0, 28'h5A5A5A5);
    check("t5_pending", 32'(bus.pending), pend_vec());
    check("t5_overflow", 32'(bus.overflow), 32'h0);
    drain();

    // Flush while presenting: everything dropped, pointer kept.
    drive_strobe(4'b0010, rand_data());
    drive_strobe(4'b0110, rand_data());
    issue_first();
    wait_valid("t6_flush_wait");
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    model_clear(1'b1);
    check("t6_flush_out", bus.meta_out, 32'h0);
    check("t6_flush_pend", 32'(bus.pending), 32'h0);
    check("t6_flush_ovf", 32'(bus.overflow), 32'h0);
    check("t6_flush_busy", 32'(bus.busy), 32'h0);
    drive_strobe(4'b1111, rand_data());
    issue_first();
    drain();

    // Randomized rounds: initial burst, extra strobes while presenting, random ack holds.
    for (int r = 0; r < 40; r++) begin
      drive_strobe(4'($urandom_range(1, 15)), rand_data());
      issue_first();
      wait_valid("rnd_first");
      repeat ($urandom_range(0, 3)) drive_strobe(4'($urandom_range(0, 15)), rand_data());
      while (cur >= 0) begin
        ack_pulse(int'($urandom_range(2, 5)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NP - 1)) : -1,
                  PW'($urandom));
      end
      check("rnd_pending", 32'(bus.pending), pend_vec());
      check("rnd_overflow", 32'(bus.overflow), ovf_vec());
    end

    // Asynchronous reset in the middle of a presented word.
    drive_strobe(4'b1000, rand_data());
    issue_first();
    wait_valid("t6_rst_wait");
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_rst_out", bus.meta_out, 32'h0);
    check("t6_rst_pend", 32'(bus.pending), 32'h0);
    check("t6_rst_busy", 32'(bus.busy), 32'h0);
    model_clear(1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    drive_strobe(4'b1111, rand_data());
    issue_first();
    drain();
    tick();

    check("end_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
